// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle between a pipeline stage register and its neighbours.
// The master side drives control and payload; the slave side returns stage state and perf counters.
interface pipe_stage_reg_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 1,
   parameter int unsigned CNT_W = 16
);
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic             bubble;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [OCC_W-1:0] occupancy;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output bubble, flush, in_valid, in_data,
      input  out_valid, out_data, occupancy, stall_cnt, flush_cnt
   );

   modport slave (
      input  bubble, flush, in_valid, in_data,
      output out_valid, out_data, occupancy, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// DEPTH-stage pipeline register with per-stage valid, bubble (hold) / flush (squash) control,
// occupancy reporting and saturating stall/flush event counters.
module pipe_stage_reg #(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      DEPTH     = 1,
   parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
   parameter int unsigned      CNT_W     = 16
) (
   input logic               clk,
   input logic               rst,
   pipe_stage_reg_if.slave   bus
);
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_data [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic             w_hold;
   logic             w_flush;
   logic [OCC_W-1:0] w_occ;

   // Bubble outranks flush; a flush raised during a stall is dropped.
   always_comb begin
      w_hold  = bus.bubble;
      w_flush = !bus.bubble && bus.flush;
   end

   // Stage shift register; invalid captures load FLUSH_VAL so empty stages stay clean.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            r_data[k] <= FLUSH_VAL;
         end
         r_valid <= '0;
      end else if (w_hold) begin
         r_valid <= r_valid;
      end else if (w_flush) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            r_data[k] <= FLUSH_VAL;
         end
         r_valid <= '0;
      end else begin
         r_valid[0] <= bus.in_valid;
         r_data[0]  <= bus.in_valid ? bus.in_data : FLUSH_VAL;
         for (int k = 1; k < int'(DEPTH); k++) begin
            r_valid[k] <= r_valid[k-1];
            r_data[k]  <= r_data[k-1];
         end
      end
   end

   // Saturating event counters, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_hold && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_flush && !(&r_flush_cnt)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   // Population count of the valid bits; depends on state only.
   always_comb begin
      w_occ = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         w_occ = w_occ + OCC_W'(r_valid[k]);
      end
   end

   assign bus.out_valid = r_valid[DEPTH-1];
   assign bus.out_data  = r_data[DEPTH-1];
   assign bus.occupancy = w_occ;
   assign bus.stall_cnt = r_stall_cnt;
   assign bus.flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a DEPTH=3 instance for reset/stream/bubble/flush and a
// DEPTH=2, CNT_W=2 instance for the invalid-gap and counter saturation cases.
module tb_pipe_stage_reg;
   localparam logic [31:0] FV_A = 32'hDEAD_BEEF;
   localparam logic [7:0]  FV_B = 8'h5A;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   pipe_stage_reg_if #(.WIDTH(32), .DEPTH(3), .CNT_W(16)) ifa ();
   pipe_stage_reg_if #(.WIDTH(8),  .DEPTH(2), .CNT_W(2))  ifb ();

   pipe_stage_reg #(.WIDTH(32), .DEPTH(3), .FLUSH_VAL(FV_A), .CNT_W(16)) u_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   pipe_stage_reg #(.WIDTH(8), .DEPTH(2), .FLUSH_VAL(FV_B), .CNT_W(2)) u_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic b, input logic f, input logic v, input logic [31:0] d);
      ifa.bubble   = b;
      ifa.flush    = f;
      ifa.in_valid = v;
      ifa.in_data  = d;
   endtask

   task automatic drive_b(input logic b, input logic f, input logic v, input logic [7:0] d);
      ifb.bubble   = b;
      ifb.flush    = f;
      ifb.in_valid = v;
      ifb.in_data  = d;
   endtask

   task automatic chk_a(input string tag, input logic v, input logic [31:0] d, input int occ);
      chk({tag, ".valid"}, 32'(ifa.out_valid), 32'(v));
      chk({tag, ".data"},  ifa.out_data, d);
      chk({tag, ".occ"},   32'(ifa.occupancy), 32'(occ));
   endtask

   task automatic chk_b(input string tag, input logic v, input logic [7:0] d, input int occ);
      chk({tag, ".valid"}, 32'(ifb.out_valid), 32'(v));
      chk({tag, ".data"},  32'(ifb.out_data), 32'(d));
      chk({tag, ".occ"},   32'(ifb.occupancy), 32'(occ));
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      drive_a(1'b0, 1'b0, 1'b0, 32'h0);
      drive_b(1'b0, 1'b0, 1'b0, 8'h0);
      #7;
      chk_a("por", 1'b0, FV_A, 0);
      chk("por.stall", 32'(ifa.stall_cnt), 32'd0);
      chk("por.flush", 32'(ifa.flush_cnt), 32'd0);
      #1 rst = 1'b0;

      // Stream three beats through DEPTH=3.
      drive_a(1'b0, 1'b0, 1'b1, 32'h11);
      tick();
      chk_a("t2.e1", 1'b0, FV_A, 1);
      drive_a(1'b0, 1'b0, 1'b1, 32'h22);
      tick();
      chk_a("t2.e2", 1'b0, FV_A, 2);
      drive_a(1'b0, 1'b0, 1'b1, 32'h33);
      tick();
      chk_a("t2.e3", 1'b1, 32'h11, 3);

      // Two bubble cycles, the second with a flush that must be dropped.
      drive_a(1'b1, 1'b0, 1'b1, 32'h44);
      tick();
      chk_a("t3.b1", 1'b1, 32'h11, 3);
      chk("t3.b1.stall", 32'(ifa.stall_cnt), 32'd1);
      drive_a(1'b1, 1'b1, 1'b1, 32'h44);
      tick();
      chk_a("t3.b2", 1'b1, 32'h11, 3);
      chk("t3.stall", 32'(ifa.stall_cnt), 32'd2);
      chk("t3.flush", 32'(ifa.flush_cnt), 32'd0);
      drive_a(1'b0, 1'b0, 1'b0, 32'h55);
      tick();
      chk_a("t3.adv", 1'b1, 32'h22, 2);

      // Effective flush discards the concurrent input.
      drive_a(1'b0, 1'b1, 1'b1, 32'hAA);
      tick();
      chk_a("t4.fl", 1'b0, FV_A, 0);
      chk("t4.flush", 32'(ifa.flush_cnt), 32'd1);
      chk("t4.stall", 32'(ifa.stall_cnt), 32'd2);
      drive_a(1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_a("t4.drain", 1'b0, FV_A, 0);
      end
      chk("t4.flush.adv", 32'(ifa.flush_cnt), 32'd1);

      // Asynchronous reset mid-stream, asserted between edges.
      drive_a(1'b0, 1'b0, 1'b1, 32'h77);
      tick();
      drive_a(1'b0, 1'b0, 1'b1, 32'h88);
      tick();
      drive_a(1'b0, 1'b0, 1'b1, 32'h99);
      tick();
      chk_a("t1.pre", 1'b1, 32'h77, 3);
      #2 rst = 1'b1;
      #1;
      chk_a("t1.async", 1'b0, FV_A, 0);
      chk("t1.stall", 32'(ifa.stall_cnt), 32'd0);
      chk("t1.flush", 32'(ifa.flush_cnt), 32'd0);
      #1 rst = 1'b0;
      drive_a(1'b0, 1'b0, 1'b1, 32'h12);
      tick();
      chk_a("t1.first", 1'b0, FV_A, 1);
      drive_a(1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      tick();
      chk_a("t1.out", 1'b1, 32'h12, 1);

      // DEPTH=2 invalid gap: captured invalid beat reads back as FLUSH_VAL.
      drive_b(1'b0, 1'b0, 1'b1, 8'h05);
      tick();
      chk_b("t6.e1", 1'b0, FV_B, 1);
      drive_b(1'b0, 1'b0, 1'b0, 8'h0F);
      tick();
      chk_b("t6.e2", 1'b1, 8'h05, 1);
      drive_b(1'b0, 1'b0, 1'b1, 8'h06);
      tick();
      chk_b("t6.e3", 1'b0, FV_B, 1);
      drive_b(1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      chk_b("t6.e4", 1'b1, 8'h06, 1);

      // CNT_W=2 saturation of both counters.
      drive_b(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk($sformatf("t5.stall%0d", i), 32'(ifb.stall_cnt), (i < 3) ? 32'(i) : 32'd3);
         chk_b("t5.frozen", 1'b1, 8'h06, 1);
      end
      drive_b(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("t5.flush%0d", i), 32'(ifb.flush_cnt), (i < 3) ? 32'(i) : 32'd3);
      end
      chk_b("t5.flushed", 1'b0, FV_B, 0);
      chk("t5.stall.keep", 32'(ifb.stall_cnt), 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
